color_freq_counter: RTL and testbench
=====================================

# color_freq_counter

Front-end measurement stage for the TCS3200-style colour sensor. Drives the sensor's filter-select lines and output enable, synchronises the sensor's square-wave output, and counts its rising edges over a fixed gate window for the clear channel and then the green channel. Each result goes out as a `freq` word with a one-cycle valid strobe and a filter tag. The green-percentage classification stage directly downstream consumes these results.

## Interface
- `GATE_CYCLES`, 50000: clk cycles per counting window (≥2).
- `SETTLE_CYCLES`, 1000: clk cycles to wait after a filter change before counting (≥1).
- `CNT_W`, 32: width of the frequency count.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request for one clear+green measurement pair.
- `continuous`  in  1  when high, a new pair starts automatically after each green report.
- `sensor_out`  in  1  raw sensor square wave, asynchronous to `clk`.
- `filter`  out  2  sensor S2/S3 select: 2'b10 = clear, 2'b11 = green.
- `sensor_oe_n`  out  1  sensor output enable, active low.
- `freq`  out  CNT_W  edge count of the completed window.
- `freq_valid`  out  1  one-cycle strobe; `freq`, `freq_tag` and `overflow` are valid in this cycle.
- `freq_tag`  out  2  filter code the result belongs to (2'b10 or 2'b11).
- `overflow`  out  1  the reported count saturated.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Input conditioning:
  - `sensor_out` passes through a 2-flop synchroniser, then one more flop for edge detection.
  - Rising-edge pulse = stage2 & ~stage3.
- FSM states: IDLE, SETTLE, GATE, REPORT. The `phase` bit selects the channel: 0 = clear, 1 = green.
- IDLE:
  - `filter`=2'b10, `sensor_oe_n`=1.
  - `start`=1 → SETTLE, with `phase`=0.
- SETTLE:
  - `filter` = `phase` ? 2'b11 : 2'b10; `sensor_oe_n`=0.
  - Waits exactly SETTLE_CYCLES cycles; edges are ignored.
  - → GATE, with the edge counter cleared.
- GATE:
  - Counts edge pulses over exactly GATE_CYCLES cycles.
  - The counter saturates at 2^CNT_W−1 and sets a sticky overflow flag; it never wraps.
  - → REPORT.
- REPORT (one cycle):
  - `freq_valid`=1; `freq` = count; `freq_tag` = current `filter`; `overflow` = the flag.
  - If `phase`=0: → SETTLE with `phase`=1.
  - Else if `continuous`=1: → SETTLE with `phase`=0.
  - Else: → IDLE.
- `freq`, `freq_tag` and `overflow` hold their last reported values between strobes.
- `start` while `busy`=1 is ignored and not queued.
- `start` and `continuous` are sampled only in IDLE and REPORT respectively.
- Dropping `continuous` mid-pair finishes the current pair, then the FSM goes to IDLE.

## Timing
- Reset (async assert; release synchronous to `clk`):
  - State IDLE, `phase`=0.
  - `filter`=2'b10, `sensor_oe_n`=1.
  - `freq`=0, `freq_valid`=0, `freq_tag`=2'b10, `overflow`=0, `busy`=0.
  - Synchroniser flops and all counters = 0.
- Reset asserted mid-measurement aborts the pair immediately. No partial result is ever reported.
- Latencies:
  - `start` high at cycle t → `busy`=1 at t+1, SETTLE begins at t+1.
  - Clear strobe at t+1+SETTLE_CYCLES+GATE_CYCLES.
  - Green strobe 1+SETTLE_CYCLES+GATE_CYCLES cycles after the clear strobe.
- Synchroniser latency of 3 cycles from a `sensor_out` edge to the counted pulse. The window is fixed in clk time, so this only shifts phase.
- A pulse coinciding with the last GATE cycle is counted. A pulse in the REPORT or SETTLE cycle is not.
- `sensor_out` high time or low time below 2 clk is out of spec; edges may be lost.
- Count width: a full window of toggling can reach at most GATE_CYCLES/2 edges, so overflow is reachable only when CNT_W is small.

## Test plan
- GATE_CYCLES=100, SETTLE_CYCLES=10; `sensor_out` period 10 clk; `start` pulse → clear strobe with `freq`=10, `freq_tag`=2'b10; then green strobe with `freq`=10, `freq_tag`=2'b11. Strobes 111 cycles apart, `overflow`=0, `busy` drops after the green report.
- Same parameters; period 20 clk during clear, period 8 clk from the green SETTLE onward → reports 5 then 12 or 13 (phase-dependent, since 100/8 is not an integer). `filter` reads 2'b10 then 2'b11 exactly in the SETTLE/GATE windows.
- CNT_W=3, period 4 clk, GATE_CYCLES=100 → `freq`=7, `overflow`=1 on both reports; the next pair with period 50 clk → `freq`=2, `overflow`=0.
- `continuous`=1 with a single `start` → four strobes alternating tags 10/11/10/11 with no IDLE gap. Deassert `continuous` during the third window → exactly four strobes, then IDLE.
- `rst_n` pulsed low mid-GATE of green → outputs at reset values at once, no strobe, `filter`=2'b10. A fresh `start` gives the correct pair.
- `start` re-pulsed while `busy` → no extra measurement; strobe count and timing unchanged.

Source files
------------

// File: rtl/color_freq_counter.sv
// color_freq_counter: drives the colour sensor filter/enable lines, synchronises
// the sensor square wave and counts its rising edges over a fixed gate window,
// first with the clear filter and then with the green filter. Each window result
// is reported as a freq word with a one-cycle strobe, a filter tag and a
// saturation flag.
module color_freq_counter #(
  parameter int GATE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             sensor_out,
  output logic [1:0]       filter,
  output logic             sensor_oe_n,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic [1:0]       freq_tag,
  output logic             overflow,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_GATE   = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  localparam logic [1:0] FLT_CLEAR = 2'b10;
  localparam logic [1:0] FLT_GREEN = 2'b11;

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             sync1_r, sync2_r, sync3_r;
  logic [1:0]       state_r, state_s;
  logic             phase_r, phase_s;
  logic [TMR_W-1:0] tmr_r, tmr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_acc_s;
  logic             ovf_r, ovf_s, ovf_acc_s;
  logic             report_s;
  logic             edge_s;
  logic [1:0]       filter_s;

  logic [1:0]       filter_r;
  logic             oe_n_r;
  logic             busy_r;
  logic [CNT_W-1:0] freq_r;
  logic             freq_valid_r;
  logic [1:0]       freq_tag_r;
  logic             overflow_r;

  assign edge_s = sync2_r & ~sync3_r;

  // Two-flop synchroniser for the asynchronous sensor wave plus one edge-detect flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= sensor_out;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Saturating edge accumulation: the count sticks at all-ones and flags overflow.
  always_comb begin
    cnt_acc_s = cnt_r;
    ovf_acc_s = ovf_r;
    if (edge_s) begin
      if (cnt_r == CNT_MAX) begin
        ovf_acc_s = 1'b1;
      end else begin
        cnt_acc_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_acc_s = cnt_r;
    end
  end

  // Measurement sequencer: next state, channel phase, window timer and count.
  always_comb begin
    state_s  = state_r;
    phase_s  = phase_r;
    tmr_s    = tmr_r;
    cnt_s    = cnt_r;
    ovf_s    = ovf_r;
    report_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tmr_s = '0;
        if (start) begin
          state_s = ST_SETTLE;
          phase_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_r == SETTLE_LAST) begin
          state_s = ST_GATE;
          tmr_s   = '0;
          cnt_s   = '0;
          ovf_s   = 1'b0;
        end else begin
          tmr_s = tmr_r + TMR_ONE;
        end
      end
      ST_GATE: begin
        cnt_s = cnt_acc_s;
        ovf_s = ovf_acc_s;
        if (tmr_r == GATE_LAST) begin
          state_s  = ST_REPORT;
          tmr_s    = '0;
          report_s = 1'b1;
        end else begin
          tmr_s = tmr_r + TMR_ONE;
        end
      end
      ST_REPORT: begin
        tmr_s = '0;
        if (!phase_r) begin
          state_s = ST_SETTLE;
          phase_s = 1'b1;
        end else if (continuous) begin
          state_s = ST_SETTLE;
          phase_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
          phase_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        phase_s = 1'b0;
        tmr_s   = '0;
      end
    endcase
  end

  // Filter select for the upcoming cycle: clear in IDLE, otherwise by phase.
  always_comb begin
    filter_s = FLT_CLEAR;
    if (state_s == ST_IDLE) begin
      filter_s = FLT_CLEAR;
    end else if (phase_s) begin
      filter_s = FLT_GREEN;
    end else begin
      filter_s = FLT_CLEAR;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      phase_r <= 1'b0;
      tmr_r   <= '0;
      cnt_r   <= '0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      tmr_r   <= tmr_s;
      cnt_r   <= cnt_s;
      ovf_r   <= ovf_s;
    end
  end

  // Registered outputs; the result fields update only on the report strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filter_r     <= FLT_CLEAR;
      oe_n_r       <= 1'b1;
      busy_r       <= 1'b0;
      freq_r       <= '0;
      freq_valid_r <= 1'b0;
      freq_tag_r   <= FLT_CLEAR;
      overflow_r   <= 1'b0;
    end else begin
      filter_r     <= filter_s;
      oe_n_r       <= (state_s == ST_IDLE);
      busy_r       <= (state_s != ST_IDLE);
      freq_valid_r <= report_s;
      if (report_s) begin
        freq_r     <= cnt_acc_s;
        freq_tag_r <= filter_r;
        overflow_r <= ovf_acc_s;
      end else begin
        freq_r     <= freq_r;
        freq_tag_r <= freq_tag_r;
        overflow_r <= overflow_r;
      end
    end
  end

  assign filter      = filter_r;
  assign sensor_oe_n = oe_n_r;
  assign busy        = busy_r;
  assign freq        = freq_r;
  assign freq_valid  = freq_valid_r;
  assign freq_tag    = freq_tag_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_color_freq_counter.sv
// Directed bench for color_freq_counter: GATE=100, SETTLE=10 on a 32-bit
// instance and a 3-bit instance for saturation.
module tb_color_freq_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b, continuous;
  logic        sensor_a, sensor_b;
  logic [1:0]  filter_a, filter_b, tag_a, tag_b;
  logic        oe_n_a, oe_n_b, fv_a, fv_b, ovf_a, ovf_b, busy_a, busy_b;
  logic [31:0] freq_a;
  logic [2:0]  freq_b;

  int cyc = 0;
  int half_a = 5;
  int half_b = 2;
  int vectors = 0;
  int miscompares = 0;
  int k;

  logic [31:0] qa_f[$];
  logic [1:0]  qa_t[$];
  logic        qa_o[$];
  int          qa_c[$];
  logic [2:0]  qb_f[$];
  logic [1:0]  qb_t[$];
  logic        qb_o[$];

  color_freq_counter #(.GATE_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(continuous),
    .sensor_out(sensor_a), .filter(filter_a), .sensor_oe_n(oe_n_a),
    .freq(freq_a), .freq_valid(fv_a), .freq_tag(tag_a), .overflow(ovf_a), .busy(busy_a));

  color_freq_counter #(.GATE_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(1'b0),
    .sensor_out(sensor_b), .filter(filter_b), .sensor_oe_n(oe_n_b),
    .freq(freq_b), .freq_valid(fv_b), .freq_tag(tag_b), .overflow(ovf_b), .busy(busy_b));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sensor wave generators: toggle every half_x clk cycles.
  initial begin
    int ca, cb;
    ca = 0; cb = 0; sensor_a = 1'b0; sensor_b = 1'b0;
    forever begin
      @(negedge clk);
      ca = ca + 1;
      if (ca >= half_a) begin sensor_a = ~sensor_a; ca = 0; end
      cb = cb + 1;
      if (cb >= half_b) begin sensor_b = ~sensor_b; cb = 0; end
    end
  end

  // Strobe recorder.
  initial forever begin
    @(negedge clk);
    #1;
    if (fv_a === 1'b1) begin
      qa_f.push_back(freq_a); qa_t.push_back(tag_a); qa_o.push_back(ovf_a); qa_c.push_back(cyc);
    end
    if (fv_b === 1'b1) begin
      qb_f.push_back(freq_b); qb_t.push_back(tag_b); qb_o.push_back(ovf_b);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
    #2;
  endtask

  // start pulse; returns the cycle in which SETTLE begins
  task automatic pulse_a(output int kk);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0; kk = cyc;
    #2;
  endtask

  task automatic pulse_b(output int kk);
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0; kk = cyc;
    #2;
  endtask

  task automatic clear_q;
    qa_f.delete(); qa_t.delete(); qa_o.delete(); qa_c.delete();
    qb_f.delete(); qb_t.delete(); qb_o.delete();
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; continuous = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_freq", freq_a, 0);
    chk("rst_fv", fv_a, 0);
    chk("rst_tag", tag_a, 2'b10);
    chk("rst_filter", filter_a, 2'b10);
    chk("rst_oe_n", oe_n_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_ovf", ovf_a, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: period 10, start re-pulsed while busy
    pulse_a(k);
    chk("t1_busy", busy_a, 1);
    chk("t1_filter", filter_a, 2'b10);
    chk("t1_oe_n", oe_n_a, 0);
    wait_until(k + 20);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_until(k + 116);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_until(k + 221);
    chk("t1_busy_rep", busy_a, 1);
    chk("t1_fv_rep", fv_a, 1);
    wait_until(k + 222);
    chk("t1_busy_end", busy_a, 0);
    chk("t1_oe_end", oe_n_a, 1);
    wait_until(k + 300);
    chk("t1_nstrobe", qa_f.size(), 2);
    if (qa_f.size() >= 2) begin
      chk("t1_clr_freq", qa_f[0], 10);
      chk("t1_clr_tag", qa_t[0], 2'b10);
      chk("t1_clr_ovf", qa_o[0], 0);
      chk("t1_clr_cyc", qa_c[0], k + 110);
      chk("t1_grn_freq", qa_f[1], 10);
      chk("t1_grn_tag", qa_t[1], 2'b11);
      chk("t1_grn_ovf", qa_o[1], 0);
      chk("t1_spacing", qa_c[1] - qa_c[0], 111);
    end
    clear_q();

    // 2: period 20 on clear, period 8 from green SETTLE
    half_a = 10;
    repeat (40) @(negedge clk);
    pulse_a(k);
    chk("t2_flt_settle", filter_a, 2'b10);
    wait_until(k + 109);
    chk("t2_flt_gate_end", filter_a, 2'b10);
    wait_until(k + 110);
    half_a = 4;
    wait_until(k + 111);
    chk("t2_flt_g_settle", filter_a, 2'b11);
    wait_until(k + 221);
    chk("t2_flt_g_rep", filter_a, 2'b11);
    wait_until(k + 222);
    chk("t2_flt_idle", filter_a, 2'b10);
    chk("t2_nstrobe", qa_f.size(), 2);
    if (qa_f.size() >= 2) begin
      chk("t2_clr_freq", qa_f[0], 5);
      chk("t2_clr_tag", qa_t[0], 2'b10);
      chk("t2_grn_freq_12_13", (qa_f[1] == 12) || (qa_f[1] == 13), 1);
      chk("t2_grn_tag", qa_t[1], 2'b11);
    end
    clear_q();

    // 3: continuous, dropped during the third window
    half_a = 5;
    repeat (30) @(negedge clk);
    continuous = 1'b1;
    pulse_a(k);
    wait_until(k + 222);
    chk("t3_busy_gap", busy_a, 1);
    wait_until(k + 280);
    continuous = 1'b0;
    wait_until(k + 444);
    chk("t3_busy_end", busy_a, 0);
    wait_until(k + 650);
    chk("t3_nstrobe", qa_f.size(), 4);
    if (qa_f.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t3_freq", qa_f[i], 10);
        chk("t3_tag", qa_t[i], (i % 2 == 0) ? 2'b10 : 2'b11);
        chk("t3_cyc", qa_c[i], k + 110 + 111 * i);
      end
    end
    clear_q();

    // 4: reset mid green GATE, then a fresh pair
    pulse_a(k);
    wait_until(k + 171);
    rst_n = 1'b0;
    #1;
    chk("t4_freq", freq_a, 0);
    chk("t4_fv", fv_a, 0);
    chk("t4_tag", tag_a, 2'b10);
    chk("t4_filter", filter_a, 2'b10);
    chk("t4_oe_n", oe_n_a, 1);
    chk("t4_busy", busy_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("t4_nstrobe_abort", qa_f.size(), 1);
    clear_q();
    pulse_a(k);
    wait_until(k + 230);
    chk("t4_nstrobe", qa_f.size(), 2);
    if (qa_f.size() >= 2) begin
      chk("t4_clr_freq", qa_f[0], 10);
      chk("t4_grn_freq", qa_f[1], 10);
      chk("t4_grn_tag", qa_t[1], 2'b11);
      chk("t4_clr_cyc", qa_c[0], k + 110);
    end
    clear_q();

    // 5: 3-bit counter saturation, then period 50
    pulse_b(k);
    wait_until(k + 230);
    chk("t5_nstrobe", qb_f.size(), 2);
    if (qb_f.size() >= 2) begin
      chk("t5_clr_freq", qb_f[0], 7);
      chk("t5_clr_ovf", qb_o[0], 1);
      chk("t5_clr_tag", qb_t[0], 2'b10);
      chk("t5_grn_freq", qb_f[1], 7);
      chk("t5_grn_ovf", qb_o[1], 1);
      chk("t5_grn_tag", qb_t[1], 2'b11);
    end
    chk("t5_hold_ovf", ovf_b, 1);
    clear_q();
    half_b = 25;
    repeat (60) @(negedge clk);
    pulse_b(k);
    wait_until(k + 230);
    chk("t5b_nstrobe", qb_f.size(), 2);
    if (qb_f.size() >= 2) begin
      chk("t5b_clr_freq", qb_f[0], 2);
      chk("t5b_clr_ovf", qb_o[0], 0);
      chk("t5b_grn_freq", qb_f[1], 2);
      chk("t5b_grn_ovf", qb_o[1], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
